// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer for the fetch stage: combinational lookup of
// the fetch PC, next-PC selection, and taken-branch target writeback from execute.
module branch_target_buffer #(
  parameter int unsigned BTB_INDEX_BITS = 4,
  parameter int unsigned PC_WIDTH       = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PC_WIDTH-1:0] pc_f,
  input  logic                pred_taken_f,
  output logic                btb_hit,
  output logic [PC_WIDTH-1:0] btb_target,
  output logic [PC_WIDTH-1:0] next_pc_pred,
  output logic                redirect_f,
  input  logic                upd_en,
  input  logic [PC_WIDTH-1:0] upd_pc,
  input  logic                upd_taken,
  input  logic [PC_WIDTH-1:0] upd_target,
  input  logic                inv_all
);

  localparam int unsigned ENTRIES = 1 << BTB_INDEX_BITS;
  localparam int unsigned TAG_W   = PC_WIDTH - BTB_INDEX_BITS;

  logic [ENTRIES-1:0]  valid_q, valid_d;
  logic [TAG_W-1:0]    tag_q    [ENTRIES];
  logic [TAG_W-1:0]    tag_d    [ENTRIES];
  logic [PC_WIDTH-1:0] target_q [ENTRIES];
  logic [PC_WIDTH-1:0] target_d [ENTRIES];

  logic [BTB_INDEX_BITS-1:0] idx_f, idx_u;
  logic [TAG_W-1:0]          tag_f, tag_u;
  logic                      wr_en;

  assign idx_f = pc_f[BTB_INDEX_BITS-1:0];
  assign tag_f = pc_f[PC_WIDTH-1:BTB_INDEX_BITS];
  assign idx_u = upd_pc[BTB_INDEX_BITS-1:0];
  assign tag_u = upd_pc[PC_WIDTH-1:BTB_INDEX_BITS];

  // Lookup reads registered state only, so a same-cycle write is not bypassed.
  always_comb begin
    btb_hit      = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
    btb_target   = target_q[idx_f];
    redirect_f   = pred_taken_f && btb_hit;
    next_pc_pred = redirect_f ? btb_target : PC_WIDTH'(pc_f + PC_WIDTH'(1));
  end

  // Invalidate-all wins over a concurrent update; not-taken updates never allocate.
  assign wr_en = upd_en && upd_taken && !inv_all;

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    if (inv_all) begin
      valid_d = '0;
    end else if (wr_en) begin
      valid_d[idx_u]  = 1'b1;
      tag_d[idx_u]    = tag_u;
      target_d[idx_u] = upd_target;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Tag and target payload need no reset; valid gates their use.
  always_ff @(posedge clk) begin
    tag_q    <= tag_d;
    target_q <= target_d;
  end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Self-checking bench for branch_target_buffer: per-cycle reference model compare
// plus directed literal expectations.
module tb_branch_target_buffer;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] pc_f;
  logic       pred_taken_f;
  logic       btb_hit;
  logic [9:0] btb_target;
  logic [9:0] next_pc_pred;
  logic       redirect_f;
  logic       upd_en;
  logic [9:0] upd_pc;
  logic       upd_taken;
  logic [9:0] upd_target;
  logic       inv_all;

  int n_cmp = 0;
  int n_bad = 0;
  bit check_en = 1'b0;

  // Reference table keyed by index, holding the full branch PC that owns the slot.
  bit m_valid [16];
  int m_pc    [16];
  int m_tgt   [16];

  branch_target_buffer #(.BTB_INDEX_BITS(4), .PC_WIDTH(10)) dut (
    .clk(clk), .rst(rst), .pc_f(pc_f), .pred_taken_f(pred_taken_f),
    .btb_hit(btb_hit), .btb_target(btb_target), .next_pc_pred(next_pc_pred),
    .redirect_f(redirect_f), .upd_en(upd_en), .upd_pc(upd_pc),
    .upd_taken(upd_taken), .upd_target(upd_target), .inv_all(inv_all)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (!rst) begin
      foreach (m_valid[i]) m_valid[i] = 1'b0;
    end else if (inv_all) begin
      foreach (m_valid[i]) m_valid[i] = 1'b0;
    end else if (upd_en && upd_taken) begin
      m_valid[upd_pc % 16] = 1'b1;
      m_pc[upd_pc % 16]    = int'(upd_pc);
      m_tgt[upd_pc % 16]   = int'(upd_target);
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      int i;
      bit e_hit;
      int e_npc;
      i     = int'(pc_f) % 16;
      e_hit = m_valid[i] && (m_pc[i] == int'(pc_f));
      e_npc = (e_hit && pred_taken_f) ? m_tgt[i] : (int'(pc_f) + 1) % 1024;
      chk("model_hit", int'(btb_hit), int'(e_hit));
      chk("model_redirect", int'(redirect_f), int'(e_hit && pred_taken_f));
      chk("model_next_pc", int'(next_pc_pred), e_npc);
      if (e_hit) chk("model_target", int'(btb_target), m_tgt[i]);
    end
  end

  // Apply one cycle of inputs just after the rising edge, then wait to mid-cycle.
  task automatic drive(input logic [9:0] pc, input logic pt, input logic ue,
                       input logic [9:0] upc, input logic ut, input logic [9:0] utgt,
                       input logic inv);
    @(posedge clk);
    #1;
    pc_f = pc; pred_taken_f = pt; upd_en = ue; upd_pc = upc;
    upd_taken = ut; upd_target = utgt; inv_all = inv;
    @(negedge clk);
    #1;
  endtask

  task automatic look(input logic [9:0] pc, input logic pt);
    drive(pc, pt, 1'b0, 10'h000, 1'b0, 10'h000, 1'b0);
  endtask

  task automatic lit(input string name, input logic hit, input logic [9:0] npc);
    chk({name, "_hit"}, int'(btb_hit), int'(hit));
    chk({name, "_npc"}, int'(next_pc_pred), int'(npc));
  endtask

  initial begin
    rst = 1'b0; pc_f = '0; pred_taken_f = 1'b0; upd_en = 1'b0; upd_pc = '0;
    upd_taken = 1'b0; upd_target = '0; inv_all = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    check_en = 1'b1;

    look(10'h012, 1'b1);
    lit("reset_miss", 1'b0, 10'h013);
    chk("reset_redirect", int'(redirect_f), 0);

    drive(10'h012, 1'b1, 1'b1, 10'h012, 1'b1, 10'h0A0, 1'b0);
    lit("no_bypass", 1'b0, 10'h013);
    look(10'h012, 1'b1);
    lit("hit_after_write", 1'b1, 10'h0A0);
    chk("hit_target", int'(btb_target), 10'h0A0);
    look(10'h012, 1'b0);
    lit("hit_not_pred", 1'b1, 10'h013);
    chk("hit_not_pred_redirect", int'(redirect_f), 0);

    drive(10'h012, 1'b1, 1'b1, 10'h022, 1'b1, 10'h150, 1'b0);
    lit("alias_preupdate", 1'b1, 10'h0A0);
    look(10'h012, 1'b1);
    lit("alias_old_miss", 1'b0, 10'h013);
    look(10'h022, 1'b1);
    lit("alias_new_hit", 1'b1, 10'h150);

    drive(10'h022, 1'b1, 1'b1, 10'h022, 1'b0, 10'h3AB, 1'b0);
    look(10'h022, 1'b1);
    lit("not_taken_keeps", 1'b1, 10'h150);

    look(10'h3FF, 1'b1);
    lit("wrap", 1'b0, 10'h000);

    for (int i = 0; i < 16; i++)
      drive(10'h3FF, 1'b0, 1'b1, 10'(i), 1'b1, 10'(10'h100 + i), 1'b0);
    for (int i = 0; i < 16; i++) begin
      look(10'(i), 1'b1);
      lit("fill", 1'b1, 10'(10'h100 + i));
    end

    drive(10'h000, 1'b1, 1'b1, 10'h005, 1'b1, 10'h1FF, 1'b1);
    lit("inv_same_cycle", 1'b1, 10'h100);
    for (int i = 0; i < 16; i++) begin
      look(10'(i), 1'b1);
      lit("after_inv", 1'b0, 10'(i + 1));
    end

    drive(10'h007, 1'b1, 1'b1, 10'h007, 1'b1, 10'h222, 1'b1);
    drive(10'h007, 1'b1, 1'b1, 10'h007, 1'b1, 10'h222, 1'b1);
    look(10'h007, 1'b1);
    lit("inv_held", 1'b0, 10'h008);

    drive(10'h009, 1'b1, 1'b1, 10'h009, 1'b1, 10'h333, 1'b0);
    look(10'h009, 1'b1);
    lit("pre_reset_hit", 1'b1, 10'h333);
    @(posedge clk);
    #1 rst = 1'b0; upd_en = 1'b1; upd_pc = 10'h00A; upd_taken = 1'b1; upd_target = 10'h044;
    @(posedge clk);
    #1 rst = 1'b1; upd_en = 1'b0;
    look(10'h009, 1'b1);
    lit("mid_reset_clears", 1'b0, 10'h00A);
    look(10'h00A, 1'b1);
    lit("mid_reset_drops_upd", 1'b0, 10'h00B);

    // Mixed traffic over a narrow PC range to provoke aliasing and same-cycle hazards.
    for (int k = 0; k < 200; k++)
      drive(10'($urandom_range(0, 63)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 10'($urandom_range(0, 63)),
            1'($urandom_range(0, 1)), 10'($urandom_range(0, 1023)),
            1'($urandom_range(0, 19) == 0));

    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
